// File: rtl/mod_sqrt_unit.sv
// Integer square root of an unsigned squared magnitude: q = floor(sqrt(r)), rem = r - q*q.
// Digit-by-digit root, one result bit per clock, with valid/ready on both sides.
`timescale 1ns/1ps
module mod_sqrt_unit #(
  parameter int IN_WIDTH  = 31,
  parameter int OUT_WIDTH = (IN_WIDTH + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  r_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] q_out,
  output logic [OUT_WIDTH:0]   rem_out
);
  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // CALC  | iterating, one root bit per cycle
  // DONE  | result held on q_out/rem_out until out_ready

  localparam int RW = 2 * OUT_WIDTH;
  localparam int MW = OUT_WIDTH + 2;
  localparam int CW = $clog2(OUT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [RW-1:0]        rad, rad_next;
  logic [OUT_WIDTH-1:0] root, root_next;
  logic [MW-1:0]        rem, rem_next, rem_shift, trial;
  logic [CW-1:0]        iter;
  logic                 take;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (iter == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // The remainder never exceeds 2*root, so shifting it by two cannot lose bits.
  always_comb begin
    rem_shift = (rem << 2) | MW'(rad[RW-1:RW-2]);
    trial     = {root, 2'b01};
    take      = (rem_shift >= trial);
    rem_next  = take ? (rem_shift - trial) : rem_shift;
    root_next = {root[OUT_WIDTH-2:0], take};
    rad_next  = {rad[RW-3:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad     <= '0;
      root    <= '0;
      rem     <= '0;
      iter    <= '0;
      q_out   <= '0;
      rem_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rad  <= RW'(r_in);
            root <= '0;
            rem  <= '0;
            iter <= CW'(OUT_WIDTH - 1);
          end
        end
        CALC: begin
          rad  <= rad_next;
          root <= root_next;
          rem  <= rem_next;
          iter <= iter - CW'(1);
          if (iter == '0) begin
            q_out   <= root_next;
            rem_out <= rem_next[OUT_WIDTH:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_sqrt_unit.sv
// Directed and randomized checks of mod_sqrt_unit against hand values and a floor(sqrt) model.
`timescale 1ns/1ps
module tb_mod_sqrt_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] r_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] q_out;
  logic [16:0] rem_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_sqrt_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .r_in(r_in),
    .out_valid(out_valid), .out_ready(out_ready), .q_out(q_out), .rem_out(rem_out)
  );

  // Drives one operand; stall>0 holds out_ready low that many cycles after out_valid.
  task automatic do_op(input logic [30:0] r, input int stall, output logic [15:0] q,
                       output logic [16:0] rem, output int lat, output bit tmo);
    int b;
    tmo = 1'b0;
    out_ready = (stall == 0);
    in_valid = 1'b1;
    r_in = r;
    b = 0;
    while (!in_ready && b < 100) begin @(posedge clk); #1; b++; end
    if (!in_ready) tmo = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) tmo = 1'b1;
    q = q_out;
    rem = rem_out;
    repeat (stall) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_out !== 16'd0 || rem_out !== 17'd0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%0d rem=%0d required 1 0 0 0",
               in_ready, out_valid, q_out, rem_out);
    end
  endtask

  task automatic test_basic();
    logic [30:0] rv [6] = '{31'd0, 31'd1, 31'd2, 31'd25, 31'd99, 31'd100};
    logic [15:0] qv [6] = '{16'd0, 16'd1, 16'd1, 16'd5, 16'd9, 16'd10};
    logic [16:0] mv [6] = '{17'd0, 17'd0, 17'd1, 17'd0, 17'd18, 17'd0};
    logic [15:0] q;
    logic [16:0] rem;
    int lat;
    bit tmo;
    for (int i = 0; i < 6; i++) begin
      do_op(rv[i], 0, q, rem, lat, tmo);
      total++;
      if (tmo !== 1'b0 || q !== qv[i] || rem !== mv[i]) begin
        bad++;
        $display("FAIL basic r=%0d: q=%0d rem=%0d tmo=%0d required q=%0d rem=%0d tmo=0",
                 rv[i], q, rem, tmo, qv[i], mv[i]);
      end
      total++;
      if (lat !== 16) begin
        bad++;
        $display("FAIL latency r=%0d: edges=%0d required 16", rv[i], lat);
      end
    end
  endtask

  task automatic test_max();
    logic [15:0] q;
    logic [16:0] rem;
    int lat;
    bit tmo;
    do_op(31'h7FFF_FFFF, 0, q, rem, lat, tmo);
    total++;
    if (tmo || q !== 16'd46340 || rem !== 17'd88047) begin
      bad++;
      $display("FAIL max: q=%0d rem=%0d required q=46340 rem=88047", q, rem);
    end
    do_op(31'd2147395600, 0, q, rem, lat, tmo);
    total++;
    if (tmo || q !== 16'd46340 || rem !== 17'd0) begin
      bad++;
      $display("FAIL perfect_square: q=%0d rem=%0d required q=46340 rem=0", q, rem);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q;
    logic [16:0] rem;
    int lat;
    int b;
    bit tmo;
    out_ready = 1'b0;
    in_valid = 1'b1;
    r_in = 31'd144;
    @(posedge clk); #1;
    in_valid = 1'b0;
    b = 0;
    while (!out_valid && b < 100) begin @(posedge clk); #1; b++; end
    total++;
    if (out_valid !== 1'b1 || q_out !== 16'd12 || rem_out !== 17'd0) begin
      bad++;
      $display("FAIL bp_result: out_valid=%b q=%0d rem=%0d required 1 12 0", out_valid, q_out, rem_out);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; r_in = 31'd9; end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== 16'd12 || rem_out !== 17'd0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b q=%0d rem=%0d required 1 0 12 0",
                 i, out_valid, in_ready, q_out, rem_out);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    do_op(31'd9, 0, q, rem, lat, tmo);
    total++;
    if (tmo || q !== 16'd3 || rem !== 17'd0) begin
      bad++;
      $display("FAIL bp_next: q=%0d rem=%0d required q=3 rem=0", q, rem);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q;
    logic [16:0] rem;
    int lat;
    int seen;
    bit tmo;
    out_ready = 1'b1;
    in_valid = 1'b1;
    r_in = 31'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0 || q_out !== 16'd0 || in_ready !== 1'b1 || rem_out !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid: out_valid=%b q=%0d in_ready=%b rem=%0d required 0 0 1 0",
               out_valid, q_out, in_ready, rem_out);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_abort: out_valid cycles=%0d required 0", seen);
    end
    do_op(31'd1000, 0, q, rem, lat, tmo);
    total++;
    if (tmo || q !== 16'd31 || rem !== 17'd39) begin
      bad++;
      $display("FAIL reset_retry: q=%0d rem=%0d required q=31 rem=39", q, rem);
    end
  endtask

  task automatic test_random();
    logic [15:0] q;
    logic [16:0] rem;
    logic [30:0] r;
    longint qm;
    longint rm;
    int lat;
    int fails;
    bit tmo;
    fails = 0;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 31'($urandom_range(0, 300));
        default: r = 31'($urandom);
      endcase
      qm = longint'($sqrt(real'(r)));
      while (qm * qm > longint'(r)) qm--;
      while ((qm + 1) * (qm + 1) <= longint'(r)) qm++;
      rm = longint'(r) - qm * qm;
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(r, int'($urandom_range(0, 4)), q, rem, lat, tmo);
      total++;
      if (tmo || longint'(q) != qm || longint'(rem) != rm || out_valid !== 1'b0) begin
        bad++;
        if (fails < 10)
          $display("FAIL random r=%0d: q=%0d rem=%0d tmo=%0d out_valid_after=%b required q=%0d rem=%0d",
                   r, q, rem, tmo, out_valid, qm, rm);
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
